// File: rtl/adc_sum_sq_acc_pkg.sv
// Shared types, width helpers and output select for the ADC power accumulator.
// Honours ADC_SUM_SQ_SATURATE_EN (saturating 32-bit output select when defined).
package adc_sum_sq_acc_pkg;

  localparam int SAMP_W_DEF = 8;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  // An unsigned square of a two's complement sample never needs the top product bit.
  function automatic int sq_w(input int samp_w);
    return 2 * samp_w - 1;
  endfunction

  function automatic int tree_w(input int samp_w, input int n_lanes);
    return 2 * samp_w - 1 + $clog2(n_lanes);
  endfunction

  function automatic logic [31:0] out_sel(input logic [63:0] v);
`ifdef ADC_SUM_SQ_SATURATE_EN
    return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
`else
    return v[31:0];
`endif
  endfunction

endpackage

// File: rtl/adc_sq_tree.sv
// P1: per-lane unsigned squares; P2: registered lane sum. Valid and sync ride along with the data.
module adc_sq_tree
  import adc_sum_sq_acc_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int SAMP_W  = SAMP_W_DEF
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [N_LANES*SAMP_W-1:0]                    data_i,
  input  logic                                         valid_i,
  input  logic                                         sync_i,
  output logic [tree_w(SAMP_W, N_LANES)-1:0]           sum_o,
  output logic                                         valid_o,
  output logic                                         sync_o
);

  localparam int SQ_W   = sq_w(SAMP_W);
  localparam int TREE_W = tree_w(SAMP_W, N_LANES);

  logic [SQ_W-1:0]   sq_d [N_LANES];
  logic [SQ_W-1:0]   sq_q [N_LANES];
  logic              v1_q, s1_q;
  logic [TREE_W-1:0] sum_d, sum_q;
  logic              v2_q, s2_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic signed [SAMP_W-1:0] samp;
    assign samp    = data_i[k*SAMP_W +: SAMP_W];
    // Evaluated at SQ_W bits: the low bits of the product are exact, (-128)^2 included.
    assign sq_d[k] = SQ_W'(samp * samp);
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_LANES; k++) sum_d = sum_d + TREE_W'(sq_q[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_LANES; k++) sq_q[k] <= '0;
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      sum_q <= '0;
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
    end else begin
      for (int k = 0; k < N_LANES; k++) sq_q[k] <= sq_d[k];
      v1_q  <= valid_i;
      s1_q  <= sync_i & valid_i;
      sum_q <= sum_d;
      v2_q  <= v1_q;
      s2_q  <= s1_q;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = v2_q;
  assign sync_o  = s2_q;

endmodule

// File: rtl/adc_sum_sq_acc.sv
// ADC input power: squares lanes, sums, accumulates 2^ACC_LEN_BITS valid clocks, dumps 32-bit result.
// Define ADC_SUM_SQ_SATURATE_EN to saturate the output instead of truncating it.
module adc_sum_sq_acc
  import adc_sum_sq_acc_pkg::*;
#(
  parameter int N_LANES      = 4,
  parameter int SAMP_W       = SAMP_W_DEF,
  parameter int ACC_LEN_BITS = 16,
  parameter int OUT_SHIFT    = 0
) (
  input  logic                        user_clk,
  input  logic                        user_rst,
  input  logic [N_LANES*SAMP_W-1:0]   adc_data,
  input  logic                        adc_valid,
  input  logic                        sync_in,
  output logic [31:0]                 sum_sq,
  output logic                        sum_sq_valid,
  output state_t                      dbg_state
);

  localparam int TREE_W = tree_w(SAMP_W, N_LANES);
  localparam int ACC_W  = TREE_W + ACC_LEN_BITS;

  logic [TREE_W-1:0]       p2_sum;
  logic                    p2_valid, p2_sync;
  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_sum;
  logic [ACC_LEN_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]             sum_sq_q, sum_sq_d;
  logic                    sum_sq_valid_q, sum_sq_valid_d;

  adc_sq_tree #(
    .N_LANES (N_LANES),
    .SAMP_W  (SAMP_W)
  ) u_sq_tree (
    .clk_i   (user_clk),
    .rst_i   (user_rst),
    .data_i  (adc_data),
    .valid_i (adc_valid),
    .sync_i  (sync_in),
    .sum_o   (p2_sum),
    .valid_o (p2_valid),
    .sync_o  (p2_sync)
  );

  assign acc_sum = acc_q + ACC_W'(p2_sum);

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    sum_sq_d       = sum_sq_q;
    sum_sq_valid_d = 1'b0;
    if (p2_valid) begin
      unique case (state_q)
        WAIT_SYNC: begin
          if (p2_sync) begin
            acc_d   = ACC_W'(p2_sum);
            cnt_d   = ACC_LEN_BITS'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          // A sync restarts the window even on the terminal sample.
          if (p2_sync) begin
            acc_d = ACC_W'(p2_sum);
            cnt_d = ACC_LEN_BITS'(1);
          end else if (cnt_q == '1) begin
            sum_sq_d       = out_sel(64'(acc_sum) >> OUT_SHIFT);
            sum_sq_valid_d = 1'b1;
            acc_d          = '0;
            cnt_d          = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + ACC_LEN_BITS'(1);
          end
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q        <= WAIT_SYNC;
      acc_q          <= '0;
      cnt_q          <= '0;
      sum_sq_q       <= '0;
      sum_sq_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      sum_sq_q       <= sum_sq_d;
      sum_sq_valid_q <= sum_sq_valid_d;
    end
  end

  assign sum_sq       = sum_sq_q;
  assign sum_sq_valid = sum_sq_valid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_sum_sq_acc.sv
// Directed bench: short-window instance for windowing/sync/reset cases, full-window instance for overflow.
module tb_adc_sum_sq_acc;
  import adc_sum_sq_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        sync_in = 1'b0;
  logic [31:0] sum_sq;
  logic        sum_sq_valid;
  state_t      dbg_state;

  logic [31:0] l_data = '0;
  logic        l_valid = 1'b0;
  logic        l_sync = 1'b0;
  logic [31:0] l_sum_sq;
  logic        l_sum_sq_valid;
  state_t      l_dbg_state;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  int l_pulses = 0;
  int c_last, p0;

  always #5 clk = ~clk;

  adc_sum_sq_acc #(.N_LANES(4), .SAMP_W(8), .ACC_LEN_BITS(4), .OUT_SHIFT(0)) dut (
    .user_clk     (clk),
    .user_rst     (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .sync_in      (sync_in),
    .sum_sq       (sum_sq),
    .sum_sq_valid (sum_sq_valid),
    .dbg_state    (dbg_state)
  );

  adc_sum_sq_acc #(.N_LANES(4), .SAMP_W(8), .ACC_LEN_BITS(16), .OUT_SHIFT(0)) dut_long (
    .user_clk     (clk),
    .user_rst     (rst),
    .adc_data     (l_data),
    .adc_valid    (l_valid),
    .sync_in      (l_sync),
    .sum_sq       (l_sum_sq),
    .sum_sq_valid (l_sum_sq_valid),
    .dbg_state    (l_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive all four lanes with v, then sample outputs 1 ns after the edge.
  task automatic step(input logic signed [7:0] v, input logic valid, input logic sync);
    adc_data  = {4{v}};
    adc_valid = valid;
    sync_in   = sync;
    @(posedge clk);
    #1;
    cyc++;
    if (sum_sq_valid) begin
      pulses++;
      pulse_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'sd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("reset_sum_sq", 64'(sum_sq), 64'h0);
    check("reset_valid", 64'(sum_sq_valid), 64'h0);
    check("reset_state", 64'(dbg_state), 64'(WAIT_SYNC));

    // 1: lanes=+1, 16 clocks -> 16*4 = 64, pulse 2 observed clocks after the last sample edge
    p0 = pulses;
    for (int i = 0; i < 16; i++) step(8'sd1, 1'b1, i == 0);
    c_last = cyc;
    idle(4);
    check("t1_pulses", 64'(pulses - p0), 64'd1);
    check("t1_latency", 64'(pulse_cyc), 64'(c_last + 2));
    check("t1_sum_sq", 64'(sum_sq), 64'd64);
    check("t1_state", 64'(dbg_state), 64'(ACCUM));

    // 2: lanes=-128 -> 4*16384*16 = 0x100000, back-to-back windows without sync
    p0 = pulses;
    for (int i = 0; i < 16; i++) step(-8'sd128, 1'b1, 1'b0);
    c_last = cyc;
    step(-8'sd128, 1'b1, 1'b0);
    step(-8'sd128, 1'b1, 1'b0);
    check("t2_first_latency", 64'(pulse_cyc), 64'(c_last + 2));
    check("t2_first_sum_sq", 64'(sum_sq), 64'h0010_0000);
    for (int i = 0; i < 14; i++) step(-8'sd128, 1'b1, 1'b0);
    idle(4);
    check("t2_pulses", 64'(pulses - p0), 64'd2);
    check("t2_second_sum_sq", 64'(sum_sq), 64'h0010_0000);

    // 3: partial window of 3s abandoned by a new sync; 16 clocks of 2s -> 16*16 = 256
    p0 = pulses;
    for (int i = 0; i < 5; i++) step(8'sd3, 1'b1, i == 0);
    for (int i = 0; i < 16; i++) step(8'sd2, 1'b1, i == 0);
    c_last = cyc;
    idle(4);
    check("t3_pulses", 64'(pulses - p0), 64'd1);
    check("t3_latency", 64'(pulse_cyc), 64'(c_last + 2));
    check("t3_sum_sq", 64'(sum_sq), 64'd256);

    // 4: valid toggles; invalid clocks carry -128 and a stray sync that must be ignored
    p0 = pulses;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        step(8'sd1, 1'b1, i == 0);
        c_last = cyc;
      end else begin
        step(-8'sd128, 1'b0, 1'b1);
      end
    end
    idle(4);
    check("t4_pulses", 64'(pulses - p0), 64'd1);
    check("t4_latency", 64'(pulse_cyc), 64'(c_last + 2));
    check("t4_sum_sq", 64'(sum_sq), 64'd64);

    // 6: reset mid-window, then unsynchronised data must not produce a dump
    for (int i = 0; i < 8; i++) step(8'sd1, 1'b1, i == 0);
    rst = 1'b1;
    step(8'sd1, 1'b1, 1'b0);
    rst = 1'b0;
    check("t6_rst_sum_sq", 64'(sum_sq), 64'h0);
    check("t6_rst_valid", 64'(sum_sq_valid), 64'h0);
    check("t6_rst_state", 64'(dbg_state), 64'(WAIT_SYNC));
    p0 = pulses;
    for (int i = 0; i < 20; i++) step(8'sd1, 1'b1, 1'b0);
    idle(4);
    check("t6_nosync_pulses", 64'(pulses - p0), 64'd0);
    check("t6_nosync_sum_sq", 64'(sum_sq), 64'h0);
    for (int i = 0; i < 16; i++) step(8'sd2, 1'b1, i == 0);
    c_last = cyc;
    idle(4);
    check("t6_pulses", 64'(pulses - p0), 64'd1);
    check("t6_latency", 64'(pulse_cyc), 64'(c_last + 2));
    check("t6_sum_sq", 64'(sum_sq), 64'd256);

    // 5: 2^16 clocks of -128 -> 65536*65536 = 2^32, beyond 32 bits
    for (int i = 0; i < 65536 + 4; i++) begin
      l_data  = {4{8'h80}};
      l_valid = (i < 65536);
      l_sync  = (i == 0);
      @(posedge clk);
      #1;
      if (l_sum_sq_valid) l_pulses++;
    end
    check("t5_pulses", 64'(l_pulses), 64'd1);
`ifdef ADC_SUM_SQ_SATURATE_EN
    check("t5_sum_sq", 64'(l_sum_sq), 64'hFFFF_FFFF);
`else
    check("t5_sum_sq", 64'(l_sum_sq), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
